// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter / drain sequencer.
package fifo_arb_pkg;

    typedef enum logic [1:0] {IDLE, READ, CAPT, HOLD} drain_state_t;

    localparam int unsigned STAT_W  = 16;
    localparam int unsigned MAX_REQ = 8;

    // One-hot pick of the first set request after ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] pick;
        int unsigned        idx;
        pick = '0;
        for (int unsigned k = 1; k <= n; k++) begin
            idx = ({29'd0, ptr} + k) % n;
            if (pick == '0 && req[idx[2:0]])
                pick[idx[2:0]] = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot pick plus registered last-winner pointer.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic [ID_W-1:0]    rr_ptr;
    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick;

    always_comb begin
        req_ext = '0;
        req_ext[N_REQ-1:0] = req;
        pick = rr_pick(req_ext, 3'(rr_ptr), N_REQ);
        // Grant is forced low while reset is held, not just after the next edge.
        grant = (reset && en) ? pick[N_REQ-1:0] : '0;
        grant_id = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            if (grant[i])
                grant_id = ID_W'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= ID_W'(N_REQ - 1);
        else if (|grant)
            rr_ptr <= grant_id;
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin FIFO write arbiter with a rate-paced valid/ready drain sequencer.
// Optional FIFO_ARB_STATS_EN adds a saturating stall counter output.
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N_REQ     = 4,
    parameter  int unsigned W         = 6,
    parameter  int unsigned DRAIN_DIV = 4,
    localparam int unsigned ID_W      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     grant,
    output logic                 fifo_we,
    output logic [W+ID_W-1:0]    fifo_data_in,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic                 fifo_re,
    input  logic [W+ID_W-1:0]    fifo_data_out,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [ID_W-1:0]      out_id,
    input  logic                 out_ready
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]    stall_cnt
`endif
);

    localparam int unsigned CNT_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

    logic [ID_W-1:0]  grant_id;
    logic [W-1:0]     payload;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             tick_pend;
    logic             issue;
    drain_state_t     state, state_n;
    logic             re_n, valid_n;
    logic [W-1:0]     data_n;
    logic [ID_W-1:0]  id_n;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .en       (~fifo_full),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        payload = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            if (grant[i])
                payload = req_data[i*W +: W];
    end

    assign fifo_we      = |grant;
    assign fifo_data_in = {grant_id, payload};

    assign tick = (tick_cnt == CNT_W'(DRAIN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt  <= '0;
            tick_pend <= 1'b0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            // A tick coinciding with an issue is kept so it is never dropped.
            tick_pend <= (tick_pend & ~issue) | tick;
        end
    end

    always_comb begin
        state_n = state;
        re_n    = 1'b0;
        issue   = 1'b0;
        valid_n = out_valid;
        data_n  = out_data;
        id_n    = out_id;
        case (state)
            IDLE: if (tick_pend && !fifo_empty) begin
                re_n    = 1'b1;
                issue   = 1'b1;
                state_n = READ;
            end
            READ: state_n = CAPT;
            CAPT: begin
                {id_n, data_n} = fifo_data_out;
                valid_n        = 1'b1;
                state_n        = HOLD;
            end
            HOLD: if (out_ready) begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fifo_re   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            state     <= state_n;
            fifo_re   <= re_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_id    <= id_n;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (|req && fifo_full && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// Self-checking bench for fifo_arbiter; the bench also plays the role of the FIFO.
`timescale 1ns/1ps
module tb_fifo_arbiter;

    localparam int N     = 4;
    localparam int W     = 6;
    localparam int IDW   = 2;
    localparam int DIV   = 4;
    localparam int DEPTH = 15;
    localparam int DW    = W + IDW;
    localparam int RDW   = N * W;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [RDW-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic           fifo_we;
    logic [DW-1:0]  fifo_data_in;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_re;
    logic [DW-1:0]  fifo_data_out = '0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           out_ready = 1'b1;
    logic           force_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]    stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    fifo_arbiter #(.N_REQ(N), .W(W), .DRAIN_DIV(DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .fifo_we       (fifo_we),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_re       (fifo_re),
        .fifo_data_out (fifo_data_out),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_id        (out_id),
        .out_ready     (out_ready)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents, last round-robin winner, expected output stream.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb[$];
    int fcount = 0;
    int model_last = N - 1;
    int stall_model = 0;

    assign fifo_full  = force_full || (fcount >= DEPTH);
    assign fifo_empty = (fcount == 0);

    function automatic int exp_pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] lane(int i);
        logic [IDW-1:0] id = IDW'(i);
        return {id, req_data[i*W +: W]};
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g = '0;
        int e;
        if (reset && !fifo_full) begin
            e = exp_pick(req, model_last);
            if (e >= 0) g[e] = 1'b1;
        end
        return g;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            fq.delete();
            sb.delete();
            fcount <= 0;
            fifo_data_out <= '0;
            model_last = N - 1;
            stall_model = 0;
        end else begin
            int e;
            if (fifo_re && fq.size() > 0) fifo_data_out <= fq.pop_front();
            if (fifo_we) fq.push_back(fifo_data_in);
            fcount <= fq.size();
            if (|req && fifo_full) stall_model++;
            if (!fifo_full) begin
                e = exp_pick(req, model_last);
                if (e >= 0) begin
                    sb.push_back(lane(e));
                    model_last = e;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        req = '0;
        force_full = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [N-1:0] r;
        logic [N-1:0] low;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            req = N'($urandom);
            req_data = RDW'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (grant !== '0 || fifo_we !== 1'b0) begin
                failures++;
                $display("FAIL reset_grant grant=%b we=%b expected 0000/0", grant, fifo_we);
            end
            checks++;
            if (fifo_re !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_id !== '0) begin
                failures++;
                $display("FAIL reset_outputs re=%b valid=%b data=%h id=%h expected all 0",
                         fifo_re, out_valid, out_data, out_id);
            end
        end
        step();
        r = N'($urandom_range(1, 15));
        low = r & (~r + 1'b1);
        req = r;
        out_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== low) begin
            failures++;
            $display("FAIL reset_first_grant req=%b grant=%b expected %b", r, grant, low);
        end
        step();
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [DW-1:0] exp_d;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            req = '1;
            req_data = RDW'($urandom);
            @(negedge clk);
            exp_d = lane(c % N);
            checks++;
            if (grant !== seq[c] || fifo_we !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant cycle=%0d grant=%b we=%b expected %b/1", c, grant, fifo_we, seq[c]);
            end
            checks++;
            if (fifo_data_in !== exp_d) begin
                failures++;
                $display("FAIL rr_data cycle=%0d data_in=%h expected %h", c, fifo_data_in, exp_d);
            end
        end
    endtask

    task automatic test_full_block();
        for (int c = 0; c < 5; c++) begin
            step();
            req = 4'b1010;
            force_full = 1'b1;
            req_data = RDW'($urandom);
            @(negedge clk);
            checks++;
            if (grant !== '0 || fifo_we !== 1'b0) begin
                failures++;
                $display("FAIL full_block cycle=%0d grant=%b we=%b expected 0000/0", c, grant, fifo_we);
            end
        end
        step();
        force_full = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0010 || fifo_we !== 1'b1 || fifo_data_in !== lane(1)) begin
            failures++;
            $display("FAIL full_release1 grant=%b we=%b data_in=%h expected 0010/1/%h",
                     grant, fifo_we, fifo_data_in, lane(1));
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (stall_cnt !== 16'(stall_model) || stall_model != 5) begin
            failures++;
            $display("FAIL stall_count stall_cnt=%0d expected 5", stall_cnt);
        end
`endif
        step();
        @(negedge clk);
        checks++;
        if (grant !== 4'b1000 || fifo_data_in !== lane(3)) begin
            failures++;
            $display("FAIL full_release2 grant=%b data_in=%h expected 1000/%h", grant, fifo_data_in, lane(3));
        end
        step();
        req = '0;
    endtask

    task automatic test_drain_single();
        int w;
        do_reset();
        out_ready = 1'b1;
        step();
        req = 4'b0100;
        req_data = RDW'($urandom);
        req_data[2*W +: W] = 6'h2A;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100 || fifo_data_in !== {2'd2, 6'h2A}) begin
            failures++;
            $display("FAIL drain_write grant=%b data_in=%h expected 0100/%h", grant, fifo_data_in, {2'd2, 6'h2A});
        end
        step();
        req = '0;
        w = 0;
        @(negedge clk);
        while (fifo_re !== 1'b1 && w < DIV + 4) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (fifo_re !== 1'b1) begin
            failures++;
            $display("FAIL drain_re_timeout re=%b expected 1 within %0d cycles", fifo_re, DIV + 4);
        end
        @(negedge clk);
        checks++;
        if (fifo_re !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_read re=%b valid=%b expected 0/0", fifo_re, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 6'h2A) begin
            failures++;
            $display("FAIL drain_capt valid=%b id=%0d data=%h expected 1/2/2a", out_valid, out_id, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_accept valid=%b expected 0", out_valid);
        end
        w = 0;
        for (int c = 0; c < 3 * DIV; c++) begin
            @(negedge clk);
            if (fifo_re === 1'b1) w++;
        end
        checks++;
        if (w != 0) begin
            failures++;
            $display("FAIL drain_empty_re re_pulses=%0d expected 0", w);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e [3];
        logic [DW-1:0] held;
        int re_cnt;
        int w;
        bit seen;
        do_reset();
        out_ready = 1'b0;
        step();
        req = 4'b1011;
        req_data = RDW'($urandom);
        e[0] = lane(0);
        e[1] = lane(1);
        e[2] = lane(3);
        step();
        step();
        step();
        req = '0;
        re_cnt = 0;
        seen = 1'b0;
        held = '0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (fifo_re === 1'b1) re_cnt++;
            if (out_valid === 1'b1) begin
                checks++;
                if (!seen && {out_id, out_data} !== e[0]) begin
                    failures++;
                    $display("FAIL bp_first_data got=%h expected %h", {out_id, out_data}, e[0]);
                end else if (seen && {out_id, out_data} !== held) begin
                    failures++;
                    $display("FAIL bp_stable cycle=%0d got=%h expected %h", c, {out_id, out_data}, held);
                end
                seen = 1'b1;
                held = {out_id, out_data};
            end
        end
        checks++;
        if (re_cnt != 1 || !seen) begin
            failures++;
            $display("FAIL bp_single_re re_pulses=%0d valid_seen=%0d expected 1/1", re_cnt, seen);
        end
        for (int k = 1; k < 3; k++) begin
            step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            w = 0;
            re_cnt = 0;
            @(negedge clk);
            while (out_valid !== 1'b1 && w < DIV + 8) begin
                if (fifo_re === 1'b1) re_cnt++;
                @(negedge clk);
                w++;
            end
            checks++;
            if (out_valid !== 1'b1 || {out_id, out_data} !== e[k] || re_cnt != 1) begin
                failures++;
                $display("FAIL bp_next entry=%0d valid=%b got=%h re_pulses=%0d expected 1/%h/1",
                         k, out_valid, {out_id, out_data}, re_cnt, e[k]);
            end
        end
        step();
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [N-1:0]  g;
        logic [N-1:0]  g_prev;
        logic [DW-1:0] held;
        logic [DW-1:0] want;
        bit holding;
        int last_re;
        int w;
        do_reset();
        g_prev = '0;
        holding = 1'b0;
        held = '0;
        last_re = -100;
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!(req[i] && !g_prev[i])) begin
                    req[i] = ($urandom_range(0, 2) == 0);
                    req_data[i*W +: W] = W'($urandom);
                end
            end
            force_full = ($urandom_range(0, 7) == 0);
            out_ready = 1'($urandom);
            @(negedge clk);
            g = exp_grant();
            g_prev = g;
            checks++;
            if (grant !== g || fifo_we !== |g) begin
                failures++;
                $display("FAIL rand_grant cycle=%0d req=%b full=%b grant=%b expected %b",
                         c, req, fifo_full, grant, g);
            end else if (|g) begin
                checks++;
                if (fifo_data_in !== lane(exp_pick(req, model_last))) begin
                    failures++;
                    $display("FAIL rand_data_in cycle=%0d got=%h expected %h",
                             c, fifo_data_in, lane(exp_pick(req, model_last)));
                end
            end
            if (fifo_re === 1'b1) begin
                checks++;
                if (c - last_re < 4 || out_valid === 1'b1) begin
                    failures++;
                    $display("FAIL rand_re_spacing cycle=%0d gap=%0d valid=%b expected gap>=4 valid=0",
                             c, c - last_re, out_valid);
                end
                last_re = c;
            end
            if (out_valid === 1'b1) begin
                if (holding) begin
                    checks++;
                    if ({out_id, out_data} !== held) begin
                        failures++;
                        $display("FAIL rand_stable cycle=%0d got=%h expected %h", c, {out_id, out_data}, held);
                    end
                end
                holding = 1'b1;
                held = {out_id, out_data};
                if (out_ready) begin
                    want = (sb.size() > 0) ? sb.pop_front() : 'x;
                    checks++;
                    if ({out_id, out_data} !== want) begin
                        failures++;
                        $display("FAIL rand_out cycle=%0d got=%h expected %h", c, {out_id, out_data}, want);
                    end
                    holding = 1'b0;
                end
            end else begin
                holding = 1'b0;
            end
        end
        step();
        req = '0;
        force_full = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while ((sb.size() > 0 || out_valid === 1'b1) && w < 300) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                want = (sb.size() > 0) ? sb.pop_front() : 'x;
                checks++;
                if ({out_id, out_data} !== want) begin
                    failures++;
                    $display("FAIL rand_tail got=%h expected %h", {out_id, out_data}, want);
                end
            end
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rand_drain_timeout remaining=%0d expected 0", sb.size());
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (stall_cnt !== 16'(stall_model)) begin
            failures++;
            $display("FAIL rand_stall_cnt stall_cnt=%0d expected %0d", stall_cnt, stall_model);
        end
`endif
    endtask

    task automatic test_reset_in_hold();
        int w;
        int bad;
        do_reset();
        out_ready = 1'b0;
        step();
        req = 4'b0001;
        req_data = RDW'($urandom);
        step();
        req = '0;
        w = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_reach valid=%b expected 1", out_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || fifo_re !== 1'b0) begin
            failures++;
            $display("FAIL hold_async_reset valid=%b data=%h id=%h re=%b expected 0/0/0/0",
                     out_valid, out_data, out_id, fifo_re);
        end
        step();
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 3 * DIV; c++) begin
            @(negedge clk);
            if (fifo_re !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_discard bad_cycles=%0d expected 0", bad);
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL hold_stall_reset stall_cnt=%0d expected 0", stall_cnt);
        end
`endif
        step();
        req = 4'b1000;
        req_data = RDW'($urandom);
        step();
        req = '0;
        w = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== req_data[3*W +: W]) begin
            failures++;
            $display("FAIL hold_restart valid=%b id=%0d data=%h expected 1/3/%h",
                     out_valid, out_id, out_data, req_data[3*W +: W]);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full_block();
        test_drain_single();
        test_backpressure();
        test_random();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
